// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// The divider datapath is built only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
  parameter int Width = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  input  logic             WeHi,
  input  logic             WeLo,
  input  logic [Width-1:0] WData,
  output logic             Busy,
  output logic             Done,
  output logic [Width-1:0] HI,
  output logic [Width-1:0] LO
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  localparam int CntW = $clog2(Width) + 1;

  state_t               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [Width-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;
  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [2*Width-1:0]   acc_q, acc_d;
  logic [Width-1:0]     mcand_q, mcand_d;
  logic                 sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic                 is_signed;
  logic [Width:0]       mul_sum;
  logic [2*Width-1:0]   prod;
`ifdef MULDIV_DIV_EN
  logic                 div_q, div_d, dz_q, dz_d;
  logic [Width:0]       div_shift;
  logic                 div_ge;
  logic [Width-1:0]     div_rem;
`endif

  function automatic logic [Width-1:0] magnitude(input logic [Width-1:0] v, input logic s);
    return (s && v[Width-1]) ? -v : v;
  endfunction

  assign is_signed = ~Op[0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    prod     = acc_q;
    mul_sum  = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
`ifdef MULDIV_DIV_EN
    div_d     = div_q;
    dz_d      = dz_q;
    div_shift = {acc_q[2*Width-1:Width], acc_q[Width-1]};
    div_ge    = div_shift >= {1'b0, mcand_q};
    // the true difference is below the divisor, so modulo-2^Width is exact
    div_rem   = div_ge ? (div_shift[Width-1:0] - mcand_q) : div_shift[Width-1:0];
`endif
    case (state_q)
      IDLE: begin
        if (WeHi) hi_d = WData;
        if (WeLo) lo_d = WData;
        if (Start) begin
`ifndef MULDIV_DIV_EN
          if (Op[1]) begin
            done_d = 1'b1;
          end else begin
`else
          begin
            div_d = Op[1];
            dz_d  = (B == '0);
`endif
            acc_d    = {{Width{1'b0}}, magnitude(A, is_signed)};
            mcand_d  = magnitude(B, is_signed);
            sign_a_d = is_signed & A[Width-1];
            sign_b_d = is_signed & B[Width-1];
            cnt_d    = '0;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CntW'(1);
        acc_d = {mul_sum, acc_q[Width-1:1]};
`ifdef MULDIV_DIV_EN
        if (div_q) acc_d = {div_rem, acc_q[Width-2:0], div_ge};
`endif
        if (cnt_q == CntW'(Width - 1)) state_d = FIX;
      end
      FIX: begin
        if (sign_a_q ^ sign_b_q) prod = -acc_q;
        {hi_d, lo_d} = prod;
`ifdef MULDIV_DIV_EN
        if (div_q) begin
          lo_d = (sign_a_q ^ sign_b_q) ? -acc_q[Width-1:0] : acc_q[Width-1:0];
          hi_d = sign_a_q ? -acc_q[2*Width-1:Width] : acc_q[2*Width-1:Width];
          // with a zero divisor the remainder path already reproduces A
          if (dz_q) lo_d = '1;
        end
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge Clock) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    sign_a_q <= sign_a_d;
    sign_b_q <= sign_b_d;
`ifdef MULDIV_DIV_EN
    div_q    <= div_d;
    dz_q     <= dz_d;
`endif
  end

  assign Busy = (state_q != IDLE);
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: vector table plus hand-written
// sequences for busy interactions, MTHI/MTLO and mid-operation reset.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic        Clock, Reset, Start, WeHi, WeLo;
  logic [1:0]  Op;
  logic [31:0] A, B, WData;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int n_chk  = 0;
  int n_fail = 0;

  muldiv_unit #(.Width(32)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .WeHi(WeHi), .WeLo(WeLo), .WData(WData),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; A = a; B = b;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (Done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc, dc;
    logic [31:0] hi_m, lo_m, exp_hi, exp_lo;
    bit noop;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4]  = '{2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{2'b00, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F};
    vecs[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9]  = '{2'b10, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF};
    vecs[10] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[11] = '{2'b00, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};

    Reset = 1'b1; Start = 1'b0; WeHi = 1'b0; WeLo = 1'b0;
    Op = 2'b00; A = '0; B = '0; WData = '0;
    tick(); tick();
    Reset = 1'b0;
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);

    WeHi = 1'b1; WData = 32'hCAFEF00D;
    tick();
    WeHi = 1'b0;
    chk("mthi_hi", HI, 32'hCAFEF00D);
    chk("mthi_lo", LO, 32'd0);
    WeLo = 1'b1; WData = 32'h11111111;
    tick();
    WeLo = 1'b0;
    chk("mtlo_lo", LO, 32'h11111111);
    chk("mtlo_hi", HI, 32'hCAFEF00D);
    hi_m = HI; lo_m = LO;

    for (int i = 0; i < 12; i++) begin
      noop = vecs[i].op[1] && !DivEn;
      exp_hi = noop ? hi_m : vecs[i].hi;
      exp_lo = noop ? lo_m : vecs[i].lo;
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy_start", i), 32'(Busy), noop ? 32'd0 : 32'd1);
      wait_done(cyc);
      chk($sformatf("v%0d_latency", i), 32'(cyc), noop ? 32'd0 : 32'd33);
      chk($sformatf("v%0d_busy_end", i), 32'(Busy), 32'd0);
      chk($sformatf("v%0d_hi", i), HI, exp_hi);
      chk($sformatf("v%0d_lo", i), LO, exp_lo);
      tick();
      chk($sformatf("v%0d_done_1cyc", i), 32'(Done), 32'd0);
      hi_m = exp_hi; lo_m = exp_lo;
    end

    // Start and MTLO while busy are both dropped
    start_op(2'b00, 32'd3, 32'd5);
    tick(); tick(); tick();
    Start = 1'b1; Op = 2'b11; A = 32'd9; B = 32'd3;
    WeLo = 1'b1; WData = 32'hDEADBEEF;
    tick();
    Start = 1'b0; WeLo = 1'b0;
    chk("busy_lo_unchanged", LO, lo_m);
    wait_done(cyc);
    chk("busy_latency", 32'(cyc + 4), 32'd33);
    chk("busy_hi", HI, 32'd0);
    chk("busy_lo", LO, 32'd15);

    // Start on the Done cycle is accepted
    start_op(2'b01, 32'd7, 32'd6);
    chk("b2b_busy", 32'(Busy), 32'd1);
    wait_done(cyc);
    chk("b2b_latency", 32'(cyc), 32'd33);
    chk("b2b_hi", HI, 32'd0);
    chk("b2b_lo", LO, 32'd42);
    tick();

    // Reset mid-operation aborts with no Done pulse
    start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) tick();
    chk("rst_mid_busy_before", 32'(Busy), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rst_mid_busy", 32'(Busy), 32'd0);
    chk("rst_mid_done", 32'(Done), 32'd0);
    chk("rst_mid_hi", HI, 32'd0);
    chk("rst_mid_lo", LO, 32'd0);
    dc = 0;
    repeat (40) begin
      tick();
      if (Done === 1'b1) dc++;
    end
    chk("rst_mid_no_done", 32'(dc), 32'd0);
    chk("rst_mid_lo_after", LO, 32'd0);

    start_op(2'b01, 32'd2, 32'd3);
    wait_done(cyc);
    chk("post_rst_latency", 32'(cyc), 32'd33);
    chk("post_rst_hi", HI, 32'd0);
    chk("post_rst_lo", LO, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS150 execute stage, sitting beside the ALU and receiving the same forwarded A/B operands. Executes MULT, MULTU, DIV and DIVU over multiple cycles into architectural HI/LO registers, and services MTHI/MTLO writes. HI/LO feed the execute-stage result mux for MFHI/MFLO. `Busy` is the pipeline stall source for any MF*/MT*/mul/div that arrives while an operation is in flight.

## Interface
Parameters:
- `Width`, 32, operand and HI/LO width; the iteration count equals `Width`.

Ports:
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  request a new operation this cycle.
- `Op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `A`  in  Width  rs operand (multiplicand/dividend).
- `B`  in  Width  rt operand (multiplier/divisor).
- `WeHi`  in  1  MTHI write enable.
- `WeLo`  in  1  MTLO write enable.
- `WData`  in  Width  MTHI/MTLO data.
- `Busy`  out  1  operation in flight; the pipeline stalls.
- `Done`  out  1  one-cycle pulse; HI/LO have just been updated by an operation.
- `HI`  out  Width  HI register (product upper half / remainder).
- `LO`  out  Width  LO register (product lower half / quotient).

## Operation
- FSM states: IDLE, RUN, FIX. Reset state is IDLE.
- Reset values: `Busy`=0, `Done`=0, `HI`=0, `LO`=0, iteration counter=0.
- IDLE: if `Start`=1, latch the magnitudes of A and B. For signed ops (MULT, DIV) the magnitude is the two's-complement absolute value; for MULTU and DIVU the operands are taken as-is. Also latch the result signs and `Op`, clear the counter, and go to RUN.
- RUN: one iteration per cycle for `Width` cycles, then go to FIX.
  - Multiply: shift-add over a 2*Width accumulator.
  - Divide: restoring divide; the partial remainder is Width+1 bits.
- FIX: apply sign correction and write HI/LO, pulse `Done`, and return to IDLE.
  - MULT: negate the 64-bit product if A and B signs differ.
  - DIV: the quotient sign is sign(A)^sign(B); the remainder sign is sign(A).
- Divide by zero (B=0): uses the same latency. Result is HI=A as presented and LO=all ones, for both DIV and DIVU.
- DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0. The magnitude path handles this naturally; no special case is needed.
- `Start` while `Busy`=1 is ignored; the pipeline must not issue it.
- `Start` in the cycle `Done`=1 is accepted, since the FSM is in IDLE that cycle.
- `WeHi`/`WeLo` in IDLE: written at the next edge.
- `WeHi`/`WeLo` while `Busy`=1 are ignored.
- `WeHi`/`WeLo` together with `Start` in IDLE: the write is applied, then overwritten by the operation result at completion.
- `Reset` mid-operation: aborts immediately. All outputs return to their reset values at that edge, and no `Done` pulse is produced.

## Timing
- Edge 0 samples `Start`=1. `Busy`=1 from after edge 0 through edge 33, inclusive of the RUN and FIX cycles.
- FIX is the cycle after edge 32. At edge 33, HI/LO update, `Busy` falls and `Done`=1 for exactly one cycle.
- Latency from `Start` edge to valid HI/LO is 33 cycles for Width=32, i.e. Width+1 in general.
- Back-to-back throughput is one operation per 34 cycles (Start accepted on the `Done` cycle).
- MTHI/MTLO latency is 1 cycle. `HI`/`LO` are registered outputs with no combinational path from the inputs.

## Configuration
- Macro: `MULDIV_DIV_EN`.
- Defined: DIV/DIVU execute as specified above.
- Undefined:
  - The divider datapath is removed.
  - DIV/DIVU `Start` is treated as a no-op: `Busy` stays 0, `Done` pulses once at the next edge, and HI/LO are unchanged.
  - MULT/MULTU are unaffected.

## Test plan
- Signed multiply: MULT A=0xFFFFFFFF, B=0x00000002 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE, `Done` pulse 1 cycle. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- Signed divide: DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=100, B=7 -> LO=14, HI=2.
- Divide by zero: DIVU A=0x12345678, B=0 -> HI=0x12345678, LO=0xFFFFFFFF, same 33-cycle latency.
- Busy interactions: during MULT 3*5, assert `Start` (DIVU 9/3) and `WeLo` with WData=0xDEADBEEF -> both ignored; final HI=0, LO=15. `Start` on the `Done` cycle -> accepted, `Busy` rises the next cycle.
- MTHI/MTLO: in IDLE, `WeHi`=1 with WData=0xCAFEF00D -> HI=0xCAFEF00D after 1 edge, LO unchanged.
- Reset mid-operation: assert `Reset` 10 cycles into MULTU 0xFFFFFFFF*0xFFFFFFFF -> `Busy`=0, HI=LO=0, no `Done` pulse. A subsequent MULTU 2*3 -> LO=6.
